// File: rtl/spk_out.sv
// rtl/spk_out.sv - spike output stage: fired-neuron FIFO expanded into one flit per destination entry
// Optional flit counter built when SPK_OUT_FLIT_CNT_EN is defined.
module spk_out #(
  parameter int             FW         = 59,
  parameter int             FTW        = 3,
  parameter int             NNW        = 12,
  parameter int             DST_WIDTH  = 21,
  parameter int             DST_DEPTH  = 4,
  parameter int             FIFO_DEPTH = 16,
  parameter logic [FTW-1:0] FLIT_TYPE  = 3'b010
) (
  input  logic                         clk_spk_out,
  input  logic                         rst_n,
  input  logic                         soma_spk_out_vld,
  input  logic                         soma_spk_out_fire,
  input  logic [NNW-1:0]               soma_spk_out_addr,
  input  logic                         config_spk_out_enable,
  input  logic [$clog2(DST_DEPTH):0]   config_spk_out_dst_num,
  input  logic                         config_spk_out_dst_we,
  input  logic [$clog2(DST_DEPTH)-1:0] config_spk_out_dst_waddr,
  input  logic [DST_WIDTH-1:0]         config_spk_out_dst_wdata,
  output logic [FW-1:0]                spk_out_flit,
  output logic                         spk_out_flit_vld,
  input  logic                         router_spk_out_rdy,
  output logic                         spk_out_busy,
  output logic                         spk_out_overflow,
  output logic [15:0]                  spk_out_flit_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int IW   = $clog2(DST_DEPTH);
  localparam int DNW  = IW + 1;
  localparam int PADW = FW - FTW - DST_WIDTH - NNW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  state_t state, state_nxt;

  logic [DNW-1:0]       dst_num_eff;
  logic [NNW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 push_req, push, pop, drop;
  logic [DST_WIDTH-1:0] dst_tbl [DST_DEPTH];
  logic [IW-1:0]        idx, idx_nxt;
  logic [NNW-1:0]       cur_addr, load_addr;
  logic [FW-1:0]        flit_q;
  logic                 load, can_pop, handshake, more_dst;
  logic                 en_q, en_rise, ovf_q;

  assign dst_num_eff = (config_spk_out_dst_num > DNW'(DST_DEPTH)) ? DNW'(DST_DEPTH)
                                                                  : config_spk_out_dst_num;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = soma_spk_out_vld && soma_spk_out_fire && config_spk_out_enable &&
                      (dst_num_eff != '0);
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_spk_out) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= soma_spk_out_addr;
  end

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DST_DEPTH; i++) dst_tbl[i] <= '0;
    end else if (config_spk_out_dst_we) begin
      dst_tbl[config_spk_out_dst_waddr] <= config_spk_out_dst_wdata;
    end
  end

  assign can_pop   = !fifo_empty && config_spk_out_enable;
  assign handshake = (state == S_SEND) && router_spk_out_rdy;
  assign more_dst  = ({1'b0, idx} + DNW'(1)) < dst_num_eff;

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (more_dst) begin
            idx_nxt = idx + IW'(1);
            load    = 1'b1;
          end else if (can_pop) begin
            pop     = 1'b1;
            load    = 1'b1;
            idx_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Table word is captured at load, so later table writes leave a presented flit intact
  assign load_addr = pop ? fifo_mem[rd_ptr[AW-1:0]] : cur_addr;

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      cur_addr <= '0;
      flit_q   <= '0;
    end else if (load) begin
      idx      <= idx_nxt;
      cur_addr <= load_addr;
      flit_q   <= {FLIT_TYPE, dst_tbl[idx_nxt], {PADW{1'b0}}, load_addr};
    end
  end

  assign en_rise = config_spk_out_enable && !en_q;

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      en_q <= config_spk_out_enable;
      if (drop)         ovf_q <= 1'b1;
      else if (en_rise) ovf_q <= 1'b0;
    end
  end

`ifdef SPK_OUT_FLIT_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n)                             cnt_q <= '0;
    else if (en_rise)                       cnt_q <= '0;
    else if (handshake && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign spk_out_flit_cnt = cnt_q;
`else
  assign spk_out_flit_cnt = '0;
`endif

  assign spk_out_flit     = flit_q;
  assign spk_out_flit_vld = (state == S_SEND);
  assign spk_out_busy     = !fifo_empty || (state == S_SEND);
  assign spk_out_overflow = ovf_q;

endmodule

// File: tb/tb_spk_out.sv
// tb/tb_spk_out.sv - directed bench for spk_out with a flit-stream scoreboard model
module tb_spk_out;
  localparam int FW = 59, NNW = 12, DW = 21, DD = 4, FD = 16;

  logic            clk_spk_out = 1'b0;
  logic            rst_n;
  logic            soma_spk_out_vld, soma_spk_out_fire;
  logic [NNW-1:0]  soma_spk_out_addr;
  logic            config_spk_out_enable;
  logic [2:0]      config_spk_out_dst_num;
  logic            config_spk_out_dst_we;
  logic [1:0]      config_spk_out_dst_waddr;
  logic [DW-1:0]   config_spk_out_dst_wdata;
  logic [FW-1:0]   spk_out_flit;
  logic            spk_out_flit_vld, router_spk_out_rdy;
  logic            spk_out_busy, spk_out_overflow;
  logic [15:0]     spk_out_flit_cnt;

  spk_out dut (
    .clk_spk_out(clk_spk_out), .rst_n(rst_n),
    .soma_spk_out_vld(soma_spk_out_vld), .soma_spk_out_fire(soma_spk_out_fire),
    .soma_spk_out_addr(soma_spk_out_addr), .config_spk_out_enable(config_spk_out_enable),
    .config_spk_out_dst_num(config_spk_out_dst_num), .config_spk_out_dst_we(config_spk_out_dst_we),
    .config_spk_out_dst_waddr(config_spk_out_dst_waddr),
    .config_spk_out_dst_wdata(config_spk_out_dst_wdata),
    .spk_out_flit(spk_out_flit), .spk_out_flit_vld(spk_out_flit_vld),
    .router_spk_out_rdy(router_spk_out_rdy), .spk_out_busy(spk_out_busy),
    .spk_out_overflow(spk_out_overflow), .spk_out_flit_cnt(spk_out_flit_cnt)
  );

  always #5 clk_spk_out = ~clk_spk_out;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: every accepted fire becomes min(dst_num,DST_DEPTH) expected flits in order
  typedef struct { logic [FW-1:0] flit; bit last; } exp_t;
  exp_t            exp_q[$];
  logic [DW-1:0]   tbl_m [DD];
  logic [NNW-1:0]  hs_addr_q[$];
  logic [FW-1:0]   prev_flit;
  logic [15:0]     cnt_m;
  int              in_sys, eff, hs_cnt = 0;
  bit              ovf_m, en_prev, hold_prev, last_hs, rise_m, drop_m;
  exp_t            e;

  function automatic logic [FW-1:0] mk_flit(input logic [DW-1:0] d, input logic [NNW-1:0] a);
    return {3'b010, d, 23'd0, a};
  endfunction

  always @(negedge clk_spk_out) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < DD; i++) tbl_m[i] = '0;
      in_sys = 0; ovf_m = 0; cnt_m = '0; en_prev = 0; hold_prev = 0;
    end else begin
      chk("overflow", spk_out_overflow, ovf_m);
`ifdef SPK_OUT_FLIT_CNT_EN
      chk("flit_cnt", spk_out_flit_cnt, cnt_m);
`else
      chk("flit_cnt_tied", spk_out_flit_cnt, 16'd0);
`endif
      if (hold_prev) begin
        chk("hold_vld", spk_out_flit_vld, 1'b1);
        chk("hold_flit", spk_out_flit, prev_flit);
      end
      last_hs = 0;
      if (spk_out_flit_vld && router_spk_out_rdy) begin
        hs_cnt++;
        hs_addr_q.push_back(spk_out_flit[NNW-1:0]);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_flit: got %0h expected none", spk_out_flit);
        end else begin
          e = exp_q.pop_front();
          chk("flit_stream", spk_out_flit, e.flit);
          last_hs = e.last;
          if (last_hs) in_sys--;
        end
      end
      hold_prev = spk_out_flit_vld && !router_spk_out_rdy;
      prev_flit = spk_out_flit;
      eff    = (config_spk_out_dst_num > 3'd4) ? 4 : int'(config_spk_out_dst_num);
      rise_m = config_spk_out_enable && !en_prev;
      drop_m = 0;
      if (soma_spk_out_vld && soma_spk_out_fire && config_spk_out_enable && eff != 0) begin
        // One neuron in service plus FD waiting; a finishing neuron frees a slot this cycle
        if (in_sys >= FD + 1) drop_m = 1;
        else begin
          for (int j = 0; j < eff; j++) begin
            e.flit = mk_flit(tbl_m[j], soma_spk_out_addr);
            e.last = (j == eff - 1);
            exp_q.push_back(e);
          end
          in_sys++;
        end
      end
      if (rise_m) ovf_m = 0;
      if (drop_m) ovf_m = 1;
      if (rise_m) cnt_m = '0;
      else if (spk_out_flit_vld && router_spk_out_rdy && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (config_spk_out_dst_we) tbl_m[config_spk_out_dst_waddr] = config_spk_out_dst_wdata;
      en_prev = config_spk_out_enable;
    end
  end

  task automatic tick();
    @(posedge clk_spk_out); #1;
  endtask

  task automatic fire(input logic [NNW-1:0] a);
    soma_spk_out_vld = 1; soma_spk_out_fire = 1; soma_spk_out_addr = a;
    tick();
    soma_spk_out_vld = 0; soma_spk_out_fire = 0;
  endtask

  task automatic wr_tbl(input logic [1:0] a, input logic [DW-1:0] d);
    config_spk_out_dst_we = 1; config_spk_out_dst_waddr = a; config_spk_out_dst_wdata = d;
    tick();
    config_spk_out_dst_we = 0;
  endtask

  logic [FW-1:0] f0, f1;
  int hs0;

  initial begin
    rst_n = 0; soma_spk_out_vld = 0; soma_spk_out_fire = 0; soma_spk_out_addr = '0;
    config_spk_out_enable = 1; config_spk_out_dst_num = 3'd2; config_spk_out_dst_we = 0;
    config_spk_out_dst_waddr = '0; config_spk_out_dst_wdata = '0; router_spk_out_rdy = 1;
    tick(); tick();
    chk("rst_flit", spk_out_flit, '0);
    chk("rst_vld", spk_out_flit_vld, 1'b0);
    chk("rst_busy", spk_out_busy, 1'b0);
    chk("rst_ovf", spk_out_overflow, 1'b0);
    chk("rst_cnt", spk_out_flit_cnt, 16'd0);
    rst_n = 1;
    wr_tbl(2'd0, 21'h12345);
    wr_tbl(2'd1, 21'h0ABCD);
    tick();
    f0 = {3'b010, 21'h12345, 23'd0, 12'h05A};
    f1 = {3'b010, 21'h0ABCD, 23'd0, 12'h05A};

    // Two destinations, router always ready
    fire(12'h05A);
    chk("t1_n1_vld", spk_out_flit_vld, 1'b0);
    chk("t1_n1_busy", spk_out_busy, 1'b1);
    tick();
    chk("t1_n2_vld", spk_out_flit_vld, 1'b1);
    chk("t1_n2_flit", spk_out_flit, f0);
    tick();
    chk("t1_n3_flit", spk_out_flit, f1);
    tick();
    chk("t1_n4_vld", spk_out_flit_vld, 1'b0);
    chk("t1_n4_busy", spk_out_busy, 1'b0);
    tick();

    // Backpressure N+2..N+6 with a table write under the held flit
    router_spk_out_rdy = 0; hs0 = hs_cnt;
    fire(12'h05A);
    tick();
    for (int i = 2; i <= 6; i++) begin
      chk("t2_hold_vld", spk_out_flit_vld, 1'b1);
      chk("t2_hold_flit", spk_out_flit, f0);
      config_spk_out_dst_we = 0;
      if (i == 3) begin
        config_spk_out_dst_we = 1; config_spk_out_dst_waddr = 2'd0;
        config_spk_out_dst_wdata = 21'h1FFFF;
      end
      tick();
    end
    router_spk_out_rdy = 1;
    chk("t2_n7_flit", spk_out_flit, f0);
    tick();
    chk("t2_n8_flit", spk_out_flit, f1);
    tick();
    chk("t2_n9_vld", spk_out_flit_vld, 1'b0);
    chk("t2_hs_count", hs_cnt - hs0, 2);
    wr_tbl(2'd0, 21'h12345);

    // Zero destinations: fire is ignored
    config_spk_out_dst_num = 3'd0; hs0 = hs_cnt;
    fire(12'h077);
    for (int i = 0; i < 4; i++) begin
      chk("t4_busy0", spk_out_busy, 1'b0);
      tick();
    end
    chk("t4_hs0", hs_cnt - hs0, 0);

    // dst_num above table depth clamps to 4
    wr_tbl(2'd2, 21'h00F0F);
    wr_tbl(2'd3, 21'h1A5A5);
    config_spk_out_dst_num = 3'd7; hs0 = hs_cnt;
    fire(12'h0C3);
    repeat (8) tick();
    chk("t4_clamp_hs", hs_cnt - hs0, 4);
    chk("t4_last_flit", spk_out_flit, {3'b010, 21'h1A5A5, 23'd0, 12'h0C3});

    // Reset while sending with 5 neurons waiting
    config_spk_out_dst_num = 3'd1; router_spk_out_rdy = 0;
    for (int i = 0; i < 6; i++) fire(NNW'(12'h100 + i));
    tick();
    chk("t5_pre_vld", spk_out_flit_vld, 1'b1);
    rst_n = 0;
    #1;
    chk("t5_async_vld", spk_out_flit_vld, 1'b0);
    chk("t5_async_busy", spk_out_busy, 1'b0);
    tick();
    rst_n = 1; router_spk_out_rdy = 1; hs0 = hs_cnt;
    repeat (10) tick();
    chk("t5_no_flits", hs_cnt - hs0, 0);
    wr_tbl(2'd0, 21'h12345);
    wr_tbl(2'd1, 21'h0ABCD);
    wr_tbl(2'd2, 21'h00F0F);
    wr_tbl(2'd3, 21'h1A5A5);

    // Three fires at four destinations
    config_spk_out_dst_num = 3'd4; hs0 = hs_cnt;
    fire(12'h201); fire(12'h202); fire(12'h203);
    repeat (16) tick();
    chk("t6_hs12", hs_cnt - hs0, 12);
`ifdef SPK_OUT_FLIT_CNT_EN
    chk("t6_cnt12", spk_out_flit_cnt, 16'd12);
`else
    chk("t6_cnt_off", spk_out_flit_cnt, 16'd0);
`endif

    // Overflow: 20 fires into a stalled output
    config_spk_out_dst_num = 3'd1; router_spk_out_rdy = 0;
    hs_addr_q.delete();
    for (int i = 0; i < 20; i++) fire(NNW'(i));
    tick();
    chk("t3_ovf", spk_out_overflow, 1'b1);
    router_spk_out_rdy = 1;
    repeat (30) tick();
    chk("t3_count", hs_addr_q.size(), 17);
    for (int i = 0; i < 17 && i < hs_addr_q.size(); i++) chk("t3_addr", hs_addr_q[i], NNW'(i));
    chk("t3_busy", spk_out_busy, 1'b0);

    // Enable low blocks pushes; rising edge clears sticky state
    config_spk_out_enable = 0; tick(); hs0 = hs_cnt;
    fire(12'h055);
    repeat (4) tick();
    chk("t7_no_push", hs_cnt - hs0, 0);
    chk("t7_ovf_kept", spk_out_overflow, 1'b1);
    config_spk_out_enable = 1;
    tick();
    chk("t7_ovf_clr", spk_out_overflow, 1'b0);
    chk("t7_cnt_clr", spk_out_flit_cnt, 16'd0);

    repeat (4) tick();
    chk("model_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
